// File: rtl/timer_countdown_core_if.sv
// Control/status bundle between the timer countdown core and its
// neighbours: the prescaler and CSR logic drive the controls, and the
// CSR/IRQ logic reads back the status.
interface timer_countdown_core_if #(
  parameter int WIDTH = 32
);
  // Controls, driven toward the core
  logic             tick;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] load_val;
  logic             irq_en;
  logic             irq_clr;

  // Status, driven by the core
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expire;
  logic             irq_flag;
  logic             irq;

  // Controller side: drives the controls and observes the status
  modport master (
    output tick, start, stop, periodic, load_val, irq_en, irq_clr,
    input  count, running, expire, irq_flag, irq
  );

  // Core side: consumes the controls and produces the status
  modport slave (
    input  tick, start, stop, periodic, load_val, irq_en, irq_clr,
    output count, running, expire, irq_flag, irq
  );
endinterface

// File: rtl/timer_countdown_core.sv
// Timer down-counter stage. Each prescaler tick decrements the count.
// When a tick arrives with the count already at zero, the timer expires:
// it pulses expire and sets the sticky irq_flag. It then either reloads
// (periodic) or parks in DONE (one-shot). Every output is registered
// except irq, which is the flag gated by the enable mask.
module timer_countdown_core #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  timer_countdown_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             expire_reg, expire_next;
  logic             irq_flag_reg, irq_flag_next;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      expire_reg   <= 1'b0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      expire_reg   <= expire_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  // Next-state logic. stop outranks start, and start outranks tick.
  // A zero count reached by the decrement is still a live count: expiry
  // happens on the following tick, so load_val=N gives N+1 ticks per period.
  always_comb begin
    logic fire;
    state_next  = state_reg;
    count_next  = count_reg;
    expire_next = 1'b0;
    fire        = 1'b0;

    if (bus.stop) begin
      state_next = IDLE;
    end else if (bus.start) begin
      count_next = bus.load_val;
      state_next = RUN;
    end else if (state_reg == RUN && bus.tick) begin
      if (count_reg != '0) begin
        count_next = count_reg - WIDTH'(1);
      end else begin
        fire = 1'b1;
        if (bus.periodic) begin
          count_next = bus.load_val;
        end else begin
          state_next = DONE;
        end
      end
    end

    expire_next = fire;
    // If an expiry and a clear arrive together, the expiry wins.
    if (fire) begin
      irq_flag_next = 1'b1;
    end else if (bus.irq_clr) begin
      irq_flag_next = 1'b0;
    end else begin
      irq_flag_next = irq_flag_reg;
    end
  end

  assign bus.count    = count_reg;
  assign bus.running  = (state_reg == RUN);
  assign bus.expire   = expire_reg;
  assign bus.irq_flag = irq_flag_reg;
  assign bus.irq      = irq_flag_reg & bus.irq_en;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Bench for timer_countdown_core. It runs a directed table of cycle-by-cycle
// vectors, a hand-written clear/expiry collision sequence, and then a
// randomized run checked against a behavioural model.
module tb_timer_countdown_core;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_countdown_core_if #(.WIDTH(W)) bus ();

  timer_countdown_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         r, t, s, p, per, en, clr;
    logic [W-1:0] ld;
    logic [W-1:0] cnt;
    bit         run, ex, flg, irq;
  } vec_t;

  vec_t tbl[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model: the mode is 0 for idle, 1 for running, 2 for done
  int           m_mode;
  logic [W-1:0] m_count;
  bit           m_flag, m_exp;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, t, s, p, per, input logic [W-1:0] ld,
                     input bit en, clr, input logic [W-1:0] cnt,
                     input bit run, ex, flg, irq);
    vec_t v;
    v.r = r; v.t = t; v.s = s; v.p = p; v.per = per; v.ld = ld;
    v.en = en; v.clr = clr; v.cnt = cnt; v.run = run; v.ex = ex;
    v.flg = flg; v.irq = irq;
    tbl.push_back(v);
  endtask

  task automatic apply(input bit r, t, s, p, per, input logic [W-1:0] ld, input bit en, clr);
    rst          = r;
    bus.tick     = t;
    bus.start    = s;
    bus.stop     = p;
    bus.periodic = per;
    bus.load_val = ld;
    bus.irq_en   = en;
    bus.irq_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] cnt,
                           input bit run, ex, flg, irq);
    chk({tag, ".count"},    bus.count,    cnt);
    chk({tag, ".running"},  W'(bus.running),  W'(run));
    chk({tag, ".expire"},   W'(bus.expire),   W'(ex));
    chk({tag, ".irq_flag"}, W'(bus.irq_flag), W'(flg));
    chk({tag, ".irq"},      W'(bus.irq),      W'(irq));
  endtask

  // Apply the timer rules to the model for one clock edge
  task automatic model_step(input bit r, t, s, p, per, input logic [W-1:0] ld, input bit clr);
    bit fire;
    fire = 1'b0;
    if (r) begin
      m_mode = 0; m_count = '0; m_flag = 1'b0;
    end else begin
      if (p) m_mode = 0;
      else if (s) begin
        m_count = ld; m_mode = 1;
      end else if (m_mode == 1 && t) begin
        if (m_count == 0) begin
          fire = 1'b1;
          if (per) m_count = ld;
          else m_mode = 2;
        end else begin
          m_count = m_count - 1;
        end
      end
      if (fire) m_flag = 1'b1;
      else if (clr) m_flag = 1'b0;
    end
    m_exp = fire;
  endtask

  initial begin
    // Columns: rst tick start stop per ld en clr | count run expire flag irq
    add(1,0,0,0,0, 0,1,0,  0,0,0,0,0);      // reset
    // Periodic, load 3
    add(0,0,1,0,1, 3,1,0,  3,1,0,0,0);
    add(0,1,0,0,1, 3,1,0,  2,1,0,0,0);
    add(0,1,0,0,1, 3,1,0,  1,1,0,0,0);
    add(0,1,0,0,1, 3,1,0,  0,1,0,0,0);
    add(0,1,0,0,1, 3,1,0,  3,1,1,1,1);
    add(0,1,0,0,1, 3,1,0,  2,1,0,1,1);
    add(0,1,0,0,1, 3,1,0,  1,1,0,1,1);
    add(0,1,0,0,1, 3,1,0,  0,1,0,1,1);
    add(0,1,0,0,1, 3,1,0,  3,1,1,1,1);
    add(0,0,0,1,1, 3,1,0,  3,0,0,1,1);      // stop
    add(0,0,0,0,1, 3,1,1,  3,0,0,0,0);      // clear flag
    // One-shot, load 2
    add(0,0,1,0,0, 2,1,0,  2,1,0,0,0);
    add(0,1,0,0,0, 2,1,0,  1,1,0,0,0);
    add(0,1,0,0,0, 2,1,0,  0,1,0,0,0);
    add(0,1,0,0,0, 2,1,0,  0,0,1,1,1);      // expire, DONE
    add(0,1,0,0,0, 2,1,0,  0,0,0,1,1);      // ticks ignored in DONE
    add(0,1,0,0,0, 2,1,0,  0,0,0,1,1);
    add(0,0,0,0,0, 2,1,1,  0,0,0,0,0);      // clear
    // irq_en masking
    add(0,0,1,0,1, 0,0,0,  0,1,0,0,0);
    add(0,1,0,0,1, 0,0,0,  0,1,1,1,0);
    add(0,0,0,0,1, 0,0,0,  0,1,0,1,0);
    add(0,0,0,0,1, 0,1,0,  0,1,0,1,1);
    // Stop and restart, load 10
    add(0,0,1,0,1,10,1,1, 10,1,0,0,0);
    add(0,1,0,0,1,10,1,0,  9,1,0,0,0);
    add(0,1,0,0,1,10,1,0,  8,1,0,0,0);
    add(0,1,0,0,1,10,1,0,  7,1,0,0,0);
    add(0,1,0,0,1,10,1,0,  6,1,0,0,0);
    add(0,0,0,1,1,10,1,0,  6,0,0,0,0);      // stop holds 6
    add(0,1,0,0,1,10,1,0,  6,0,0,0,0);
    add(0,1,0,0,1,10,1,0,  6,0,0,0,0);
    add(0,0,1,0,1,10,1,0, 10,1,0,0,0);
    add(0,0,1,1,1,10,1,0, 10,0,0,0,0);      // stop beats start
    add(0,0,1,0,1,10,1,0, 10,1,0,0,0);
    add(0,1,0,0,1,10,1,0,  9,1,0,0,0);
    add(0,1,1,0,1, 7,1,0,  7,1,0,0,0);      // restart swallows the tick
    // Load 0, periodic: expire on every tick while tick is held high
    add(0,0,1,0,1, 0,1,0,  0,1,0,0,0);
    add(0,1,0,0,1, 0,1,0,  0,1,1,1,1);
    add(0,1,0,0,1, 0,1,0,  0,1,1,1,1);
    add(0,1,0,0,1, 0,1,0,  0,1,1,1,1);
    add(0,1,0,0,1, 0,1,0,  0,1,1,1,1);
    add(0,1,0,0,1, 0,1,0,  0,1,1,1,1);
    add(0,0,0,0,1, 0,1,0,  0,1,0,1,1);
    // Reset mid-run
    add(0,0,1,0,1, 5,1,0,  5,1,0,1,1);
    add(1,1,0,0,1, 5,1,0,  0,0,0,0,0);
    add(0,0,1,0,1, 0,1,0,  0,1,0,0,0);
    add(1,1,0,0,1, 0,1,0,  0,0,0,0,0);      // would have expired
    add(0,1,0,0,1, 0,1,0,  0,0,0,0,0);      // idle ignores tick

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].p, tbl[i].per, tbl[i].ld, tbl[i].en, tbl[i].clr);
      $display("[TB] vec %0d cnt=%0d run=%0b exp=%0b flag=%0b irq=%0b",
               i, bus.count, bus.running, bus.expire, bus.irq_flag, bus.irq);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].run, tbl[i].ex, tbl[i].flg, tbl[i].irq);
    end

    // Hand-written collision: a clear in the expiry cycle loses, and a clear one cycle later wins
    apply(0,0,1,0,0, 1,1,0);
    check_all("col.start", 1, 1, 0, 0, 0);
    apply(0,1,0,0,0, 1,1,0);
    check_all("col.dec", 0, 1, 0, 0, 0);
    apply(0,1,0,0,0, 1,1,1);
    check_all("col.exp_clr", 0, 0, 1, 1, 1);
    apply(0,0,0,0,0, 1,1,1);
    check_all("col.clr", 0, 0, 0, 0, 0);

    // Randomized run against the model; start from a reset
    apply(1,0,0,0,0, 0,0,0);
    m_mode = 0; m_count = '0; m_flag = 1'b0; m_exp = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit r, t, s, p, per, en, clr;
      logic [W-1:0] ld;
      r   = ($urandom_range(0, 99) < 2);
      p   = ($urandom_range(0, 99) < 5);
      s   = ($urandom_range(0, 99) < 8);
      t   = ($urandom_range(0, 99) < 60);
      per = $urandom_range(0, 1);
      en  = $urandom_range(0, 1);
      clr = ($urandom_range(0, 99) < 10);
      ld  = ($urandom_range(0, 9) < 8) ? W'($urandom_range(0, 5)) : W'($urandom);
      model_step(r, t, s, p, per, ld, clr);
      apply(r, t, s, p, per, ld, en, clr);
      $display("[TB] rnd %0d cnt=%0d run=%0b exp=%0b flag=%0b", n, bus.count, bus.running, bus.expire, bus.irq_flag);
      check_all($sformatf("rnd%0d", n), m_count, (m_mode == 1), m_exp, m_flag, m_flag & en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
